vending_machine_p: RTL

- Parametrised successor to the single-price vending machine controller: N selectable items, per-item prices and per-item stock counters.
- Adds per-button debounce, cancel/refund and change return, and saturating credit with coin rejection.
- Sits between the board push-buttons/switches (coins, choice, cancel) and the display and LED drivers (total, cost_or_ret, item, status).
- Runs on a single 100 MHz clock.

---
 rtl/vending_machine_p.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/vending_machine_p.sv
// Multi-item vending controller with per-item prices and stock, debounced buttons,
// saturating credit with coin rejection, and cancel/refund through a single change cycle.
module vending_machine_p #(
    parameter int                        NUM_ITEMS       = 4,
    parameter int                        CW              = 8,
    parameter logic [NUM_ITEMS*CW-1:0]   PRICES          = {8'd30, 8'd25, 8'd20, 8'd15},
    parameter logic [3*CW-1:0]           COIN_VALS       = {8'd25, 8'd10, 8'd5},
    parameter logic [CW-1:0]             MAX_CREDIT      = 8'd200,
    parameter int                        STOCK_W         = 4,
    parameter logic [STOCK_W-1:0]        STOCK_INIT      = 4'd8,
    parameter int                        DEBOUNCE_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [2:0]            in,
    input  logic [NUM_ITEMS-1:0]  choice,
    input  logic                  cancel,
    output logic [NUM_ITEMS-1:0]  item,
    output logic [CW-1:0]         total,
    output logic [CW-1:0]         cost_or_ret,
    output logic                  change_valid,
    output logic                  coin_reject,
    output logic [NUM_ITEMS-1:0]  sold_out,
    output logic [1:0]            state_o
);

    localparam int DB_N  = 4 + NUM_ITEMS;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int IW    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int AW    = CW + 2;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_total;
    logic [CW-1:0]          r_cost;
    logic [NUM_ITEMS-1:0]   r_item;
    logic                   r_changeValid;
    logic                   r_coinReject;
    logic [IW-1:0]          r_sel;
    logic [STOCK_W-1:0]     r_stock [NUM_ITEMS];

    logic [CNT_W-1:0]       r_dbCnt [DB_N];
    logic [DB_N-1:0]        r_filt;
    logic [3:0]             r_filtPrev;

    logic [DB_N-1:0]        w_raw;
    logic [3:0]             w_edge;
    logic [2:0]             w_coinEdge;
    logic                   w_cancelEdge;
    logic [NUM_ITEMS-1:0]   w_choiceLvl;
    logic [AW-1:0]          w_coinSum;
    logic [AW-1:0]          w_newTotal;
    logic                   w_overMax;
    logic [IW-1:0]          w_choiceIdx;
    logic                   w_choiceOneHot;
    logic                   w_choiceOk;
    logic [CW-1:0]          w_price;
    logic [NUM_ITEMS-1:0]   w_soldOut;

    assign w_raw = {choice, cancel, in};

    // Each button level is accepted only after it has differed from the filtered level for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DB_N; i++) begin
                r_dbCnt[i] <= '0;
            end
            r_filt     <= '0;
            r_filtPrev <= '0;
        end else begin
            r_filtPrev <= r_filt[3:0];
            for (int i = 0; i < DB_N; i++) begin
                if (w_raw[i] == r_filt[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == DB_LAST) begin
                    r_filt[i]  <= w_raw[i];
                    r_dbCnt[i] <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_edge       = r_filt[3:0] & ~r_filtPrev;
    assign w_coinEdge   = w_edge[2:0];
    assign w_cancelEdge = w_edge[3];
    assign w_choiceLvl  = r_filt[DB_N-1:4];

    always_comb begin
        w_coinSum = '0;
        for (int k = 0; k < 3; k++) begin
            if (w_coinEdge[k]) begin
                w_coinSum = w_coinSum + AW'(COIN_VALS[k*CW +: CW]);
            end
        end
    end

    // Widened sum so a saturating deposit is detected instead of wrapping.
    assign w_newTotal = AW'(r_total) + w_coinSum;
    assign w_overMax  = w_newTotal > AW'(MAX_CREDIT);

    always_comb begin
        w_choiceIdx = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (w_choiceLvl[i]) begin
                w_choiceIdx = IW'(i);
            end
        end
    end

    assign w_choiceOneHot = (w_choiceLvl != '0) &&
                            ((w_choiceLvl & (w_choiceLvl - NUM_ITEMS'(1))) == '0);
    assign w_choiceOk     = w_choiceOneHot && (r_stock[w_choiceIdx] != '0);
    assign w_price        = PRICES[int'(r_sel)*CW +: CW];

    always_comb begin
        w_soldOut = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            w_soldOut[i] = (r_stock[i] == '0);
        end
    end

    // Credit, stock and all display outputs are registered alongside the state so they line up with it.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state       <= S_IDLE;
            r_total       <= '0;
            r_cost        <= '0;
            r_item        <= '0;
            r_changeValid <= 1'b0;
            r_coinReject  <= 1'b0;
            r_sel         <= '0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                r_stock[i] <= STOCK_INIT;
            end
        end else begin
            r_item        <= '0;
            r_changeValid <= 1'b0;
            r_coinReject  <= 1'b0;

            if (|w_coinEdge) begin
                if (r_state == S_VEND || r_state == S_CHANGE || w_overMax) begin
                    r_coinReject <= 1'b1;
                end else begin
                    r_total <= w_newTotal[CW-1:0];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cancelEdge && r_total != '0) begin
                        r_state       <= S_CHANGE;
                        r_cost        <= r_total;
                        r_changeValid <= 1'b1;
                    end else if (w_choiceOk) begin
                        r_state <= S_SELECT;
                        r_sel   <= w_choiceIdx;
                        r_cost  <= PRICES[int'(w_choiceIdx)*CW +: CW];
                    end
                end
                S_SELECT: begin
                    if (w_cancelEdge) begin
                        r_state       <= S_CHANGE;
                        r_cost        <= r_total;
                        r_changeValid <= 1'b1;
                    end else if (r_total >= w_price) begin
                        r_state <= S_VEND;
                        r_cost  <= '0;
                        r_item  <= NUM_ITEMS'(1) << r_sel;
                    end
                end
                S_VEND: begin
                    if (r_stock[r_sel] != '0) begin
                        r_stock[r_sel] <= r_stock[r_sel] - STOCK_W'(1);
                    end
                    r_state       <= S_CHANGE;
                    r_cost        <= r_total - w_price;
                    r_changeValid <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_total <= '0;
                    r_cost  <= '0;
                end
            endcase
        end
    end

    assign item         = r_item;
    assign total        = r_total;
    assign cost_or_ret  = r_cost;
    assign change_valid = r_changeValid;
    assign coin_reject  = r_coinReject;
    assign sold_out     = w_soldOut;
    assign state_o      = r_state;

endmodule
